// File: rtl/csa_seq_adder_ctrl.sv
// Sequential WIDTH-bit add/subtract built from one shared 5-bit carry-select slice.
// Slices are processed LSB first; the inter-slice carry is held in a register.
module csa_seq_adder_ctrl #(
  parameter int WIDTH = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int NSLICE = WIDTH / 5;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  generate
    if ((WIDTH % 5) != 0) begin : g_width_check
      $error("csa_seq_adder_ctrl: WIDTH must be a multiple of 5");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Carry-select slice: both carry-in outcomes are formed, the registered carry picks one.
  function automatic logic [5:0] csa_slice(input logic [4:0] a, input logic [4:0] b,
                                           input logic cin);
    logic [5:0] sum0;
    logic [5:0] sum1;
    sum0 = {1'b0, a} + {1'b0, b};
    sum1 = {1'b0, a} + {1'b0, b} + 6'd1;
    return cin ? sum1 : sum0;
  endfunction

  state_t           state_r, state_s;
  logic [IDXW-1:0]  idx_r, idx_s;
  logic             carry_r, carry_s;
  logic [WIDTH-1:0] a_r, a_s;
  logic [WIDTH-1:0] b_r, b_s;
  logic             ready_r, ready_s;
  logic             valid_r, valid_s;
  logic [WIDTH-1:0] sum_r, sum_s;
  logic             cout_r, cout_s;
  logic             ovf_r, ovf_s;
  logic [31:0]      base_s;
  logic [5:0]       slice_s;

  assign base_s  = 32'(idx_r) * 32'd5;
  assign slice_s = csa_slice(a_r[base_s +: 5], b_r[base_s +: 5], carry_r);

  // Next-state and next-output logic for the sequencing FSM.
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    carry_s = carry_r;
    a_s     = a_r;
    b_s     = b_r;
    ready_s = ready_r;
    valid_s = valid_r;
    sum_s   = sum_r;
    cout_s  = cout_r;
    ovf_s   = ovf_r;
    case (state_r)
      IDLE: begin
        if (ready_r && in_valid) begin
          a_s     = in_a;
          b_s     = in_sub ? ~in_b : in_b;
          carry_s = in_sub;
          idx_s   = '0;
          ready_s = 1'b0;
          state_s = RUN;
        end else begin
          ready_s = 1'b1;
        end
      end
      RUN: begin
        sum_s[base_s +: 5] = slice_s[4:0];
        carry_s            = slice_s[5];
        if (idx_r == LAST_IDX) begin
          // slice_s[4] is the result MSB on the final slice
          cout_s  = slice_s[5];
          ovf_s   = (a_r[WIDTH-1] == b_r[WIDTH-1]) && (slice_s[4] != a_r[WIDTH-1]);
          valid_s = 1'b1;
          idx_s   = '0;
          state_s = DONE;
        end else begin
          idx_s = idx_r + IDXW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          valid_s = 1'b0;
          ready_s = 1'b1;
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
        ready_s = 1'b0;
        valid_s = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      idx_r   <= '0;
      carry_r <= 1'b0;
      a_r     <= '0;
      b_r     <= '0;
      ready_r <= 1'b0;
      valid_r <= 1'b0;
      sum_r   <= '0;
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
      carry_r <= carry_s;
      a_r     <= a_s;
      b_r     <= b_s;
      ready_r <= ready_s;
      valid_r <= valid_s;
      sum_r   <= sum_s;
      cout_r  <= cout_s;
      ovf_r   <= ovf_s;
    end
  end

  assign in_ready  = ready_r;
  assign out_valid = valid_r;
  assign out_sum   = sum_r;
  assign out_cout  = cout_r;
  assign out_ovf   = ovf_r;

endmodule
